// File: rtl/ff_excitation_driver.sv
// Initiator for an external flop bank: turns a target next-state word into J/K, S/R and D
// excitation, then checks the bank's q feedback one cycle after the drive and counts misses.
module ff_excitation_driver #(
    parameter int WIDTH   = 4,
    parameter bit DC_FILL = 1'b0
) (
    input  logic             clk,
    input  logic             async_reset,
    input  logic             i_tgt_valid,
    output logic             o_tgt_ready,
    input  logic [WIDTH-1:0] i_tgt_data,
    output logic [WIDTH-1:0] o_j,
    output logic [WIDTH-1:0] o_k,
    output logic [WIDTH-1:0] o_s,
    output logic [WIDTH-1:0] o_r,
    output logic [WIDTH-1:0] o_d,
    input  logic [WIDTH-1:0] i_fb_q,
    output logic             o_busy,
    output logic             o_mismatch,
    output logic [WIDTH-1:0] o_err_mask,
    output logic [7:0]       o_err_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        CHECK = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_cur;
    logic [WIDTH-1:0] r_exp;
    logic [WIDTH-1:0] r_j, r_k, r_s, r_r, r_d;
    logic             r_ready;
    logic             r_busy;
    logic             r_mismatch;
    logic [WIDTH-1:0] r_err_mask;
    logic [7:0]       r_err_count;

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_q;
    logic [WIDTH-1:0] w_n;
    logic [WIDTH-1:0] w_j, w_k, w_s, w_r;
    logic [WIDTH-1:0] w_m;
    logic             w_accept;

    assign w_x = {WIDTH{DC_FILL}};
    // In CHECK the next drive must start from what the bank really holds, not from the old cur.
    assign w_q = (r_state == CHECK) ? i_fb_q : r_cur;
    assign w_n = i_tgt_data;
    assign w_m = i_fb_q ^ r_exp;
    assign w_accept = i_tgt_valid && r_ready;

    // Don't-care bits take DC_FILL; S and R are never both 1 since their care terms are disjoint.
    always_comb begin
        w_j = (~w_q & w_n) | (w_q & w_x);
        w_k = (w_q & ~w_n) | (~w_q & w_x);
        w_s = (~w_q & w_n) | (w_q & w_n & w_x);
        w_r = (w_q & ~w_n) | (~w_q & ~w_n & w_x);
    end

    always_ff @(posedge clk or posedge async_reset) begin
        if (async_reset) begin
            r_state     <= IDLE;
            r_cur       <= '0;
            r_exp       <= '0;
            r_j         <= '0;
            r_k         <= '0;
            r_s         <= '0;
            r_r         <= '0;
            r_d         <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_mismatch  <= 1'b0;
            r_err_mask  <= '0;
            r_err_count <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_mismatch <= 1'b0;
                    if (w_accept) begin
                        r_exp   <= w_n;
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_s     <= w_s;
                        r_r     <= w_r;
                        r_d     <= w_n;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= DRIVE;
                    end
                end
                DRIVE: begin
                    r_j        <= '0;
                    r_k        <= '0;
                    r_s        <= '0;
                    r_r        <= '0;
                    r_d        <= r_cur;
                    r_ready    <= 1'b1;
                    r_busy     <= 1'b1;
                    r_mismatch <= 1'b0;
                    r_state    <= CHECK;
                end
                CHECK: begin
                    r_cur      <= i_fb_q;
                    r_mismatch <= |w_m;
                    r_err_mask <= w_m;
                    if (|w_m && r_err_count != 8'hFF)
                        r_err_count <= r_err_count + 8'd1;
                    if (w_accept) begin
                        r_exp   <= w_n;
                        r_j     <= w_j;
                        r_k     <= w_k;
                        r_s     <= w_s;
                        r_r     <= w_r;
                        r_d     <= w_n;
                        r_ready <= 1'b0;
                        r_busy  <= 1'b1;
                        r_state <= DRIVE;
                    end else begin
                        r_j     <= '0;
                        r_k     <= '0;
                        r_s     <= '0;
                        r_r     <= '0;
                        r_d     <= i_fb_q;
                        r_ready <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_tgt_ready = r_ready;
    assign o_j         = r_j;
    assign o_k         = r_k;
    assign o_s         = r_s;
    assign o_r         = r_r;
    assign o_d         = r_d;
    assign o_busy      = r_busy;
    assign o_mismatch  = r_mismatch;
    assign o_err_mask  = r_err_mask;
    assign o_err_count = r_err_count;

endmodule
